mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Registered two-port arbiter sharing the single MainMem line port between the instruction cache and the data cache.
- Replaces the combinational steering currently between the caches and MainMem.
- Latches one request at a time, holds the memory command stable until Ready_Mem, then returns the line to the winning cache with a one-cycle ready pulse.
- Round-robin when both caches request; data cache wins ties after reset.

Parameters:
- ADDR_W, 32, address width of the cache and memory ports.
- LINE_W, 128, cache line width in bits.
- TIMEOUT, 255, max cycles waiting for mem_ready before err_timeout; 0 disables.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- i_read  in  1  instruction cache line-read request.
- i_write  in  1  instruction cache line-write request.
- i_addr  in  ADDR_W  instruction cache line address.
- i_wdata  in  LINE_W  instruction cache write line.
- i_rdata  out  LINE_W  line returned to instruction cache.
- i_ready  out  1  one-cycle completion pulse to instruction cache.
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready: same as the i_* ports, for the data cache.
- mem_read  out  1  to MainMem OE.
- mem_write  out  1  to MainMem WE.
- mem_addr  out  ADDR_W  to MainMem Addr.
- mem_wdata  out  LINE_W  to MainMem Data_in.
- mem_rdata  in  LINE_W  from MainMem Data_out.
- mem_ready  in  1  from MainMem Ready_Mem.
- err_timeout  out  1  sticky; set when TIMEOUT expires.

Behaviour:
- Reset (async) values:
  - state=IDLE, last_grant=I (so data wins the first tie).
  - mem_read, mem_write, i_ready, d_ready, err_timeout = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0; wait counter = 0.
- States: IDLE, BUSY_I, BUSY_D.
- Request eligibility:
  - req_x = x_read | x_write.
  - req_x is masked in any cycle where x_ready=1, because the requester is still dropping its request.
- IDLE arbitration:
  - Only one eligible request: grant it.
  - Both eligible: grant the one that is not last_grant.
  - On grant: latch addr and wdata into mem_addr/mem_wdata; set mem_write=x_write and mem_read=x_read & ~x_write (write wins if both are asserted); update last_grant; go to BUSY_x; clear the wait counter.
  - Latency: request sampled in cycle N, memory command visible in cycle N+1.
- BUSY_x:
  - mem_read, mem_write, mem_addr and mem_wdata are held constant; requester inputs are ignored (a changing request is not re-latched).
  - The wait counter increments each cycle, saturating at TIMEOUT.
- mem_ready=1 sampled in BUSY_x:
  - Next cycle: x_rdata <= mem_rdata (for writes too, so the value is don't-care for the requester); x_ready=1 for exactly one cycle; mem_read and mem_write drop to 0; state=IDLE.
  - The other requester can be granted in that same IDLE cycle; the served requester cannot.
  - Minimum turnaround: 1 IDLE cycle between consecutive memory commands.
- x_rdata holds its value until the next completion for x.
- Timeout:
  - When TIMEOUT!=0 and the counter reaches TIMEOUT in BUSY: err_timeout<=1 (sticky until reset).
  - The state stays BUSY; no abort.
- mem_ready in IDLE is ignored.
- reset asserted mid-transaction: immediately abandon the command (mem_read/mem_write=0), no ready pulse, return to IDLE; the requesters re-request afterwards.
- mem_read and mem_write are never both 1.
- At most one of i_ready/d_ready is high in any cycle.

Test Plan:
- Single D read at addr 0x40, memory responds with 0xAAAA..._0001 after 3 cycles -> mem_read=1 for exactly 4 cycles with mem_addr=0x40; d_ready pulses once; d_rdata=0xAAAA..._0001; i_ready stays 0.
- i_read(0x100) and d_write(0x200, 0x1234) asserted together after reset -> D granted first with mem_write=1, mem_addr=0x200, mem_wdata=0x1234; after d_ready, I granted in that same IDLE cycle (mem_read=1, mem_addr=0x100 on the next cycle).
- Both requesters hold requests continuously for 6 transactions -> grant order D, I, D, I, D, I; no requester ever served twice in a row.
- i_read and i_write both asserted, addr 0x80 -> mem_write=1, mem_read=0.
- TIMEOUT=4, mem_ready never asserted -> err_timeout rises on the 5th BUSY cycle and stays 1; no ready pulse. Then assert reset -> err_timeout=0, mem_read=0, state IDLE.
- Reset asserted 2 cycles into BUSY_D -> mem_write/mem_read go to 0 asynchronously; d_ready never pulses; d_rdata=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Registered two-port arbiter that shares the single MainMem line port between
// the instruction cache (i_*) and the data cache (d_*).
// One request is latched at a time. The memory command is held stable until
// mem_ready, and then the line goes back to the winning cache with a one-cycle
// ready pulse.
// When both caches request at once, the grant alternates. The data cache wins
// the first tie after reset.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   i_read/i_write          instruction cache line read / write request
//   i_addr/i_wdata          instruction cache line address / write line
//   i_rdata/i_ready         line returned / one-cycle completion pulse
//   d_*                     same set for the data cache
//   mem_read/mem_write      MainMem OE / WE (never both high)
//   mem_addr/mem_wdata      MainMem Addr / Data_in
//   mem_rdata/mem_ready     MainMem Data_out / Ready_Mem
//   err_timeout             sticky, set when a command waits TIMEOUT cycles
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err_timeout
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic              r_lastGrantD;
    logic              r_memRead;
    logic              r_memWrite;
    logic [ADDR_W-1:0] r_memAddr;
    logic [LINE_W-1:0] r_memWdata;
    logic [LINE_W-1:0] r_iRdata;
    logic [LINE_W-1:0] r_dRdata;
    logic              r_iReady;
    logic              r_dReady;
    logic              r_err;
    logic [CNT_W-1:0]  r_waitCnt;
    logic [CNT_W-1:0]  w_waitCntInc;
    logic              w_reqI;
    logic              w_reqD;
    logic              w_grantI;
    logic              w_grantD;
    logic              w_done;

    // A cache that is seeing its ready pulse this cycle still has its request
    // up, because it only reacts to the pulse on the following edge. Masking it
    // here keeps the same request from being served a second time.
    assign w_reqI = (i_read | i_write) & ~r_iReady;
    assign w_reqD = (d_read | d_write) & ~r_dReady;

    // The wait counter saturates, so a memory that never answers cannot wrap
    // it back to zero.
    assign w_waitCntInc = (r_waitCnt == TIMEOUT_C) ? r_waitCnt : r_waitCnt + CNT_W'(1);

    // Next-state logic and grant decision.
    // In IDLE, a lone eligible request is granted at once. On a tie, the cache
    // that did not win last time gets the port.
    // A busy state only leaves when memory signals ready. There is no abort,
    // even after a timeout.
    always_comb begin
        w_stateNext = r_state;
        w_grantI    = 1'b0;
        w_grantD    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_reqI && w_reqD) begin
                    if (r_lastGrantD) begin
                        w_grantI = 1'b1;
                    end else begin
                        w_grantD = 1'b1;
                    end
                end else if (w_reqI) begin
                    w_grantI = 1'b1;
                end else if (w_reqD) begin
                    w_grantD = 1'b1;
                end
                if (w_grantI) begin
                    w_stateNext = BUSY_I;
                end else if (w_grantD) begin
                    w_stateNext = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    w_done      = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Datapath registers.
    // A grant latches the winner's command. On a read/write collision the write
    // wins.
    // While busy, the command is frozen and the counter runs.
    // On completion the returned line is steered to the owner, and its ready
    // pulse is raised for one cycle.
    // last_grant resets to the instruction cache, so the data cache wins the
    // first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lastGrantD <= 1'b0;
            r_memRead    <= 1'b0;
            r_memWrite   <= 1'b0;
            r_memAddr    <= '0;
            r_memWdata   <= '0;
            r_iRdata     <= '0;
            r_dRdata     <= '0;
            r_iReady     <= 1'b0;
            r_dReady     <= 1'b0;
            r_err        <= 1'b0;
            r_waitCnt    <= '0;
        end else begin
            r_iReady <= 1'b0;
            r_dReady <= 1'b0;
            if (w_grantI) begin
                r_memAddr    <= i_addr;
                r_memWdata   <= i_wdata;
                r_memWrite   <= i_write;
                r_memRead    <= i_read & ~i_write;
                r_lastGrantD <= 1'b0;
                r_waitCnt    <= '0;
            end else if (w_grantD) begin
                r_memAddr    <= d_addr;
                r_memWdata   <= d_wdata;
                r_memWrite   <= d_write;
                r_memRead    <= d_read & ~d_write;
                r_lastGrantD <= 1'b1;
                r_waitCnt    <= '0;
            end else if (w_done) begin
                r_memRead  <= 1'b0;
                r_memWrite <= 1'b0;
                if (r_state == BUSY_I) begin
                    r_iRdata <= mem_rdata;
                    r_iReady <= 1'b1;
                end else begin
                    r_dRdata <= mem_rdata;
                    r_dReady <= 1'b1;
                end
            end else if (r_state != IDLE) begin
                r_waitCnt <= w_waitCntInc;
                if ((TIMEOUT != 0) && (w_waitCntInc == TIMEOUT_C)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign mem_read    = r_memRead;
    assign mem_write   = r_memWrite;
    assign mem_addr    = r_memAddr;
    assign mem_wdata   = r_memWdata;
    assign i_rdata     = r_iRdata;
    assign i_ready     = r_iReady;
    assign d_rdata     = r_dRdata;
    assign d_ready     = r_dReady;
    assign err_timeout = r_err;

endmodule
